// File: rtl/l2_buffer_scheduler.sv
// rtl/l2_buffer_scheduler.sv - round-robin access scheduler for the L2 staging buffer
//
// Purpose:
//   Sequences L1 single-word and DDR burst accesses onto a single-port
//   circular buffer of 2^ADDR_W words. The module tracks the write pointer,
//   read pointer and occupancy, and drives the buffer enable, write enable
//   and address. Arbitration is round-robin. A request is granted only if
//   the access cannot overflow or underflow the queue.
//
// Optional feature:
//   Defining L2_SCHED_WATERMARK_EN adds the parameters AF_LEVEL and AE_LEVEL
//   and the outputs o_almost_full and o_almost_empty.
//
// Ports:
//   clk_170M        clock
//   rst_n           asynchronous active-low reset
//   i_l1_req        L1 word request, held until o_l1_gnt
//   i_l1_rw         L1 direction: 1 = read (pop), 0 = write (push)
//   o_l1_gnt        one-cycle grant; the buffer access happens in the same cycle
//   i_ddr_req       DDR burst request, held until o_ddr_gnt
//   i_ddr_rw        DDR direction: 1 = drain burst, 0 = fill burst
//   o_ddr_gnt       pulse on the first beat of a granted burst
//   o_ddr_busy      high on every beat of a burst
//   o_mem_en        buffer enable
//   o_mem_we        buffer write enable
//   o_mem_addr      buffer word address
//   o_count         occupancy in words
//   o_full          occupancy == 2^ADDR_W - 1
//   o_empty         occupancy == 0
//   o_almost_full   (watermark build only) occupancy >= AF_LEVEL
//   o_almost_empty  (watermark build only) occupancy <= AE_LEVEL

module l2_buffer_scheduler #(
  parameter int ADDR_W    = 12,
  parameter int BURST_LEN = 8
`ifdef L2_SCHED_WATERMARK_EN
  ,
  parameter int AF_LEVEL  = 4088,
  parameter int AE_LEVEL  = 8
`endif
) (
  input  logic              clk_170M,
  input  logic              rst_n,
  input  logic              i_l1_req,
  input  logic              i_l1_rw,
  output logic              o_l1_gnt,
  input  logic              i_ddr_req,
  input  logic              i_ddr_rw,
  output logic              o_ddr_gnt,
  output logic              o_ddr_busy,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [ADDR_W-1:0] o_count,
  output logic              o_full,
  output logic              o_empty
`ifdef L2_SCHED_WATERMARK_EN
  ,
  output logic              o_almost_full,
  output logic              o_almost_empty
`endif
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  // Thresholds are one bit wider than the count, so "capacity - burst" cannot wrap.
  localparam logic [ADDR_W:0]   CAP_X   = (ADDR_W+1)'((1 << ADDR_W) - 1);
  localparam logic [ADDR_W:0]   ONE_X   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   BURST_X = (ADDR_W+1)'(BURST_LEN);
  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);
  localparam logic [BEAT_W-1:0] ONE_B   = BEAT_W'(1);
  localparam logic [BEAT_W-1:0] LAST_B  = BEAT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_L1_ACC  = 2'd1,
    S_DDR_ACC = 2'd2
  } state_t;

  // Sequencing state
  state_t              state_q, state_d;
  logic                rw_q, rw_d;
  logic                last_ddr_q, last_ddr_d;  // 1: DDR won the last arbitration
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]   count_q, count_d;

  // Registered outputs
  logic                l1_gnt_q, l1_gnt_d;
  logic                ddr_gnt_q, ddr_gnt_d;
  logic                ddr_busy_q, ddr_busy_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                full_q, full_d;
  logic                empty_q, empty_d;
`ifdef L2_SCHED_WATERMARK_EN
  logic                af_q, af_d;
  logic                ae_q, ae_d;
`endif

  logic [ADDR_W:0]     count_x;
  logic                l1_elig;
  logic                ddr_elig;
  logic                l1_win;
  logic                ddr_win;

  assign count_x  = {1'b0, count_q};
  assign l1_elig  = i_l1_req  && (i_l1_rw  ? (count_x >= ONE_X)   : (count_x <= CAP_X - ONE_X));
  assign ddr_elig = i_ddr_req && (i_ddr_rw ? (count_x >= BURST_X) : (count_x <= CAP_X - BURST_X));
  // When both requesters are eligible, the requester that did not win last time wins now.
  assign ddr_win  = ddr_elig && (!l1_elig || !last_ddr_q);
  assign l1_win   = l1_elig  && (!ddr_elig || last_ddr_q);

  // State register
  always_ff @(posedge clk_170M or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rw_q       <= 1'b0;
      last_ddr_q <= 1'b0;
      beat_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      l1_gnt_q   <= 1'b0;
      ddr_gnt_q  <= 1'b0;
      ddr_busy_q <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
`ifdef L2_SCHED_WATERMARK_EN
      af_q       <= 1'b0;
      ae_q       <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      rw_q       <= rw_d;
      last_ddr_q <= last_ddr_d;
      beat_q     <= beat_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      l1_gnt_q   <= l1_gnt_d;
      ddr_gnt_q  <= ddr_gnt_d;
      ddr_busy_q <= ddr_busy_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
`ifdef L2_SCHED_WATERMARK_EN
      af_q       <= af_d;
      ae_q       <= ae_d;
`endif
    end
  end

  // Next-state logic: arbitration, beat sequencing and queue bookkeeping.
  // Each access cycle, including every DDR beat, moves one pointer by one word.
  always_comb begin
    state_d    = state_q;
    rw_d       = rw_q;
    last_ddr_d = last_ddr_q;
    beat_d     = beat_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    unique case (state_q)
      S_IDLE: begin
        beat_d = '0;
        if (ddr_win) begin
          state_d    = S_DDR_ACC;
          rw_d       = i_ddr_rw;
          last_ddr_d = 1'b1;
        end else if (l1_win) begin
          state_d    = S_L1_ACC;
          rw_d       = i_l1_rw;
          last_ddr_d = 1'b0;
        end
      end

      S_L1_ACC: begin
        if (rw_q) begin
          rd_ptr_d = rd_ptr_q + ONE_A;
          count_d  = count_q - ONE_A;
        end else begin
          wr_ptr_d = wr_ptr_q + ONE_A;
          count_d  = count_q + ONE_A;
        end
        state_d = S_IDLE;
      end

      S_DDR_ACC: begin
        if (rw_q) begin
          rd_ptr_d = rd_ptr_q + ONE_A;
          count_d  = count_q - ONE_A;
        end else begin
          wr_ptr_d = wr_ptr_q + ONE_A;
          count_d  = count_q + ONE_A;
        end
        if (beat_q == LAST_B) begin
          state_d = S_IDLE;
          beat_d  = '0;
        end else begin
          beat_d  = beat_q + ONE_B;
        end
      end

      default: begin
        state_d = S_IDLE;
        beat_d  = '0;
      end
    endcase
  end

  // Output logic: the outputs for the coming cycle are derived from the next
  // state and next pointers, so every output comes straight from a flop.
  always_comb begin
    l1_gnt_d   = (state_d == S_L1_ACC);
    ddr_busy_d = (state_d == S_DDR_ACC);
    ddr_gnt_d  = (state_d == S_DDR_ACC) && (beat_d == '0);
    mem_en_d   = (state_d != S_IDLE);
    mem_we_d   = mem_en_d && !rw_d;
    mem_addr_d = '0;
    if (mem_en_d) begin
      mem_addr_d = rw_d ? rd_ptr_d : wr_ptr_d;
    end
    full_d     = (count_d == '1);
    empty_d    = (count_d == '0);
`ifdef L2_SCHED_WATERMARK_EN
    af_d       = ({1'b0, count_d} >= (ADDR_W+1)'(AF_LEVEL));
    ae_d       = ({1'b0, count_d} <= (ADDR_W+1)'(AE_LEVEL));
`endif
  end

  assign o_l1_gnt   = l1_gnt_q;
  assign o_ddr_gnt  = ddr_gnt_q;
  assign o_ddr_busy = ddr_busy_q;
  assign o_mem_en   = mem_en_q;
  assign o_mem_we   = mem_we_q;
  assign o_mem_addr = mem_addr_q;
  assign o_count    = count_q;
  assign o_full     = full_q;
  assign o_empty    = empty_q;
`ifdef L2_SCHED_WATERMARK_EN
  assign o_almost_full  = af_q;
  assign o_almost_empty = ae_q;
`endif

endmodule

// File: tb/tb_l2_buffer_scheduler.sv
// tb/tb_l2_buffer_scheduler.sv - self-checking bench for l2_buffer_scheduler
`timescale 1ns/1ps
module tb_l2_buffer_scheduler;
  localparam int ADDR_W    = 12;
  localparam int BURST_LEN = 8;
  localparam int DEPTH     = 1 << ADDR_W;
  localparam int CAP       = DEPTH - 1;

  logic              clk_170M = 1'b0;
  logic              rst_n;
  logic              i_l1_req, i_l1_rw, i_ddr_req, i_ddr_rw;
  logic              o_l1_gnt, o_ddr_gnt, o_ddr_busy, o_mem_en, o_mem_we, o_full, o_empty;
  logic [ADDR_W-1:0] o_mem_addr, o_count;

  int total = 0;
  int bad   = 0;

  // Reference model: queue occupancy, pointers and the arbitration history.
  int m_count, m_wr, m_rd;
  bit m_last_ddr;

  l2_buffer_scheduler #(.ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN)) dut (
    .clk_170M   (clk_170M),
    .rst_n      (rst_n),
    .i_l1_req   (i_l1_req),
    .i_l1_rw    (i_l1_rw),
    .o_l1_gnt   (o_l1_gnt),
    .i_ddr_req  (i_ddr_req),
    .i_ddr_rw   (i_ddr_rw),
    .o_ddr_gnt  (o_ddr_gnt),
    .o_ddr_busy (o_ddr_busy),
    .o_mem_en   (o_mem_en),
    .o_mem_we   (o_mem_we),
    .o_mem_addr (o_mem_addr),
    .o_count    (o_count),
    .o_full     (o_full),
    .o_empty    (o_empty)
  );

  always #3 clk_170M = ~clk_170M;

  task automatic model_reset();
    m_count = 0; m_wr = 0; m_rd = 0; m_last_ddr = 1'b0;
  endtask

  task automatic drop_reqs();
    i_l1_req = 1'b0; i_l1_rw = 1'b0; i_ddr_req = 1'b0; i_ddr_rw = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk_170M);
    rst_n = 1'b0;
    drop_reqs();
    @(negedge clk_170M);
    @(negedge clk_170M);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Presents one request pattern in IDLE (called at a negedge) and checks the
  // outcome predicted from the queue rules until the scheduler is idle again.
  task automatic txn(input bit l1r, input bit l1rw, input bit dr, input bit drw,
                     input int nhold, input string tag);
    bit e_l1, e_d, rw;
    int win, addr0;
    logic [ADDR_W-1:0] exp_addr, exp_cnt;
    e_l1 = l1r && (l1rw ? (m_count >= 1) : (m_count <= CAP - 1));
    e_d  = dr && (drw ? (m_count >= BURST_LEN) : (m_count <= CAP - BURST_LEN));
    if (e_l1 && e_d) win = m_last_ddr ? 1 : 2;
    else if (e_d)    win = 2;
    else if (e_l1)   win = 1;
    else             win = 0;
    i_l1_req = l1r; i_l1_rw = l1rw; i_ddr_req = dr; i_ddr_rw = drw;
    @(posedge clk_170M);
    @(negedge clk_170M);
    if (win == 0) begin
      for (int c = 0; c < nhold; c++) begin
        total++;
        if (o_l1_gnt !== 1'b0 || o_ddr_gnt !== 1'b0 || o_mem_en !== 1'b0) begin
          bad++;
          $display("FAIL %s no_grant c%0d: l1_gnt=%b ddr_gnt=%b mem_en=%b required 0 0 0",
                   tag, c, o_l1_gnt, o_ddr_gnt, o_mem_en);
        end
        exp_cnt = ADDR_W'(m_count);
        total++;
        if (o_count !== exp_cnt) begin
          bad++;
          $display("FAIL %s hold_count: got %0d required %0d", tag, o_count, exp_cnt);
        end
        @(posedge clk_170M);
        @(negedge clk_170M);
      end
      drop_reqs();
    end else begin
      rw    = (win == 1) ? l1rw : drw;
      addr0 = rw ? m_rd : m_wr;
      for (int b = 0; b < ((win == 1) ? 1 : BURST_LEN); b++) begin
        exp_addr = ADDR_W'((addr0 + b) % DEPTH);
        exp_cnt  = ADDR_W'(rw ? (m_count - b) : (m_count + b));
        total++;
        if (o_l1_gnt !== (win == 1) || o_ddr_gnt !== (win == 2 && b == 0) ||
            o_ddr_busy !== (win == 2)) begin
          bad++;
          $display("FAIL %s grant b%0d: l1_gnt=%b ddr_gnt=%b busy=%b required win=%0d",
                   tag, b, o_l1_gnt, o_ddr_gnt, o_ddr_busy, win);
        end
        total++;
        if (o_mem_en !== 1'b1 || o_mem_we !== !rw) begin
          bad++;
          $display("FAIL %s mem_ctl b%0d: en=%b we=%b required 1 %b", tag, b, o_mem_en, o_mem_we, !rw);
        end
        total++;
        if (o_mem_addr !== exp_addr) begin
          bad++;
          $display("FAIL %s addr b%0d: got %0d required %0d", tag, b, o_mem_addr, exp_addr);
        end
        total++;
        if (o_count !== exp_cnt) begin
          bad++;
          $display("FAIL %s beat_count b%0d: got %0d required %0d", tag, b, o_count, exp_cnt);
        end
        if (b == 0) drop_reqs();
        @(posedge clk_170M);
        @(negedge clk_170M);
      end
      if (win == 1) begin
        m_count = rw ? m_count - 1 : m_count + 1;
        m_last_ddr = 1'b0;
      end else begin
        m_count = rw ? m_count - BURST_LEN : m_count + BURST_LEN;
        m_last_ddr = 1'b1;
      end
      if (rw) m_rd = (m_rd + ((win == 1) ? 1 : BURST_LEN)) % DEPTH;
      else    m_wr = (m_wr + ((win == 1) ? 1 : BURST_LEN)) % DEPTH;
      exp_cnt = ADDR_W'(m_count);
      total++;
      if (o_l1_gnt !== 1'b0 || o_ddr_busy !== 1'b0 || o_mem_en !== 1'b0) begin
        bad++;
        $display("FAIL %s idle_after: l1_gnt=%b busy=%b en=%b required 0 0 0",
                 tag, o_l1_gnt, o_ddr_busy, o_mem_en);
      end
      total++;
      if (o_count !== exp_cnt || o_full !== (m_count == CAP) || o_empty !== (m_count == 0)) begin
        bad++;
        $display("FAIL %s count_after: count=%0d full=%b empty=%b required %0d %b %b",
                 tag, o_count, o_full, o_empty, exp_cnt, (m_count == CAP), (m_count == 0));
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if (o_l1_gnt !== 1'b0 || o_ddr_gnt !== 1'b0 || o_ddr_busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_grants: l1_gnt=%b ddr_gnt=%b busy=%b required 0 0 0", o_l1_gnt, o_ddr_gnt, o_ddr_busy);
    end
    total++;
    if (o_mem_en !== 1'b0 || o_mem_we !== 1'b0 || o_mem_addr !== 12'd0) begin
      bad++;
      $display("FAIL reset_mem: en=%b we=%b addr=%0d required 0 0 0", o_mem_en, o_mem_we, o_mem_addr);
    end
    total++;
    if (o_count !== 12'd0 || o_empty !== 1'b1 || o_full !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags: count=%0d empty=%b full=%b required 0 1 0", o_count, o_empty, o_full);
    end
  endtask

  task automatic test_l1_write();
    apply_reset();
    for (int i = 0; i < 3; i++) txn(1, 0, 0, 0, 1, "l1_write");
    total++;
    if (o_count !== 12'd3 || o_empty !== 1'b0) begin
      bad++;
      $display("FAIL l1_write_final: count=%0d empty=%b required 3 0", o_count, o_empty);
    end
  endtask

  task automatic test_ddr_read();
    apply_reset();
    for (int i = 0; i < 8; i++) txn(1, 0, 0, 0, 1, "fill8");
    txn(0, 0, 1, 1, 1, "ddr_read");
    total++;
    if (o_count !== 12'd0 || o_empty !== 1'b1) begin
      bad++;
      $display("FAIL ddr_read_final: count=%0d empty=%b required 0 1", o_count, o_empty);
    end
  endtask

  task automatic test_arbitration();
    apply_reset();
    txn(1, 0, 1, 0, 1, "arb_first");
    txn(1, 0, 1, 0, 1, "arb_second");
    total++;
    if (o_count !== 12'd9) begin
      bad++;
      $display("FAIL arb_final_count: got %0d required 9", o_count);
    end
  endtask

  task automatic test_underflow_block();
    apply_reset();
    txn(1, 1, 0, 0, 20, "empty_read_held");
    txn(1, 1, 1, 0, 1, "fill_while_read");
    txn(1, 1, 0, 0, 1, "read_after_fill");
    total++;
    if (o_count !== 12'd7) begin
      bad++;
      $display("FAIL underflow_final_count: got %0d required 7", o_count);
    end
  endtask

  task automatic test_full_wrap();
    apply_reset();
    for (int i = 0; i < CAP / BURST_LEN; i++) txn(0, 0, 1, 0, 1, "fill_ddr");
    for (int i = 0; i < CAP % BURST_LEN; i++) txn(1, 0, 0, 0, 1, "fill_l1");
    total++;
    if (o_count !== 12'd4095 || o_full !== 1'b1) begin
      bad++;
      $display("FAIL full_reached: count=%0d full=%b required 4095 1", o_count, o_full);
    end
    txn(1, 0, 0, 0, 5, "l1_write_full");
    txn(0, 0, 1, 0, 5, "ddr_write_full");
    txn(1, 1, 0, 0, 1, "read_at_full");
    total++;
    if (o_full !== 1'b0) begin
      bad++;
      $display("FAIL full_release: full=%b required 0", o_full);
    end
    txn(1, 0, 0, 0, 1, "write_top");
    txn(1, 1, 0, 0, 1, "read_second");
    txn(1, 0, 0, 0, 1, "write_wrapped");
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    i_ddr_req = 1'b1; i_ddr_rw = 1'b0;
    @(posedge clk_170M);
    @(negedge clk_170M);
    drop_reqs();
    for (int b = 0; b < 3; b++) begin
      @(posedge clk_170M);
      @(negedge clk_170M);
    end
    total++;
    if (o_ddr_busy !== 1'b1 || o_mem_addr !== 12'd3) begin
      bad++;
      $display("FAIL beat3_reached: busy=%b addr=%0d required 1 3", o_ddr_busy, o_mem_addr);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (o_ddr_busy !== 1'b0 || o_ddr_gnt !== 1'b0 || o_mem_en !== 1'b0 ||
        o_mem_we !== 1'b0 || o_mem_addr !== 12'd0) begin
      bad++;
      $display("FAIL async_reset_outs: busy=%b gnt=%b en=%b we=%b addr=%0d required all 0",
               o_ddr_busy, o_ddr_gnt, o_mem_en, o_mem_we, o_mem_addr);
    end
    total++;
    if (o_count !== 12'd0 || o_empty !== 1'b1) begin
      bad++;
      $display("FAIL async_reset_count: count=%0d empty=%b required 0 1", o_count, o_empty);
    end
    @(negedge clk_170M);
    rst_n = 1'b1;
    model_reset();
    txn(1, 0, 0, 0, 1, "write_after_abort");
  endtask

  task automatic test_random();
    bit l1r, l1rw, dr, drw;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      l1r  = ($urandom_range(0, 3) != 0);
      l1rw = $urandom_range(0, 1);
      dr   = ($urandom_range(0, 3) != 0);
      drw  = $urandom_range(0, 1);
      txn(l1r, l1rw, dr, drw, 2, "random");
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drop_reqs();
    model_reset();
    test_reset();
    test_l1_write();
    test_ddr_read();
    test_arbitration();
    test_underflow_block();
    test_full_wrap();
    test_reset_mid_burst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
